// File: rtl/dlx_pipe_stage_reg.sv
// Inter-stage pipeline register for the uDLX pipeline: valid/ready handshake,
// optional 2-entry skid buffer, flush to bubbles with gated control bits.
module dlx_pipe_stage_reg #(
  parameter int unsigned DATA_WIDTH = 84,
  parameter int unsigned CTRL_WIDTH = 8,
  parameter int unsigned SKID_EN    = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_in,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            occupancy
);

  logic                  r_main_valid;
  logic [CTRL_WIDTH-1:0] r_main_ctrl;
  logic [DATA_WIDTH-1:0] r_main_data;

  logic                  w_skid_valid;
  logic [CTRL_WIDTH-1:0] w_skid_ctrl;
  logic [DATA_WIDTH-1:0] w_skid_data;

  logic w_clear;
  logic w_in_xfer;
  logic w_main_load;

  assign w_clear     = !rst_n || flush_in;
  assign w_in_xfer   = in_valid && in_ready;
  // Main is free this edge when empty or when its entry leaves downstream.
  assign w_main_load = !r_main_valid || out_ready;

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_main_valid <= 1'b0;
      r_main_ctrl  <= '0;
      r_main_data  <= '0;
    end else if (w_main_load) begin
      if (w_skid_valid) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= w_skid_ctrl;
        r_main_data  <= w_skid_data;
      end else if (w_in_xfer) begin
        r_main_valid <= 1'b1;
        r_main_ctrl  <= in_ctrl;
        r_main_data  <= in_data;
      end else begin
        r_main_valid <= 1'b0;
      end
    end
  end

  generate
    if (SKID_EN != 0) begin : g_skid
      logic                  r_skid_valid;
      logic [CTRL_WIDTH-1:0] r_skid_ctrl;
      logic [DATA_WIDTH-1:0] r_skid_data;

      // Skid only captures while main is stalled; it is always drained into main first.
      always_ff @(posedge clk) begin
        if (w_clear) begin
          r_skid_valid <= 1'b0;
          r_skid_ctrl  <= '0;
          r_skid_data  <= '0;
        end else if (w_main_load && r_skid_valid) begin
          r_skid_valid <= 1'b0;
        end else if (!w_main_load && w_in_xfer) begin
          r_skid_valid <= 1'b1;
          r_skid_ctrl  <= in_ctrl;
          r_skid_data  <= in_data;
        end
      end

      assign w_skid_valid = r_skid_valid;
      assign w_skid_ctrl  = r_skid_ctrl;
      assign w_skid_data  = r_skid_data;
      assign in_ready     = !r_skid_valid;
    end else begin : g_noskid
      assign w_skid_valid = 1'b0;
      assign w_skid_ctrl  = '0;
      assign w_skid_data  = '0;
      assign in_ready     = !r_main_valid || out_ready;
    end
  endgenerate

  assign out_valid = r_main_valid;
  assign out_ctrl  = r_main_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, r_main_valid} + {1'b0, w_skid_valid};

endmodule

// File: tb/tb_dlx_pipe_stage_reg.sv
// Bench for dlx_pipe_stage_reg: instance 0 with skid buffer, instance 1 without,
// checked by a FIFO scoreboard fed on accepted inputs and drained on outputs.
module tb_dlx_pipe_stage_reg;

  localparam int unsigned DW = 84;
  localparam int unsigned CW = 8;
  typedef logic [CW+DW-1:0] ent_t;

  logic          clk;
  logic          rst_n;
  logic          flush_in  [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [CW-1:0] in_ctrl   [2];
  logic [DW-1:0] in_data   [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [CW-1:0] out_ctrl  [2];
  logic [DW-1:0] out_data  [2];
  logic [1:0]    occ       [2];

  ent_t sb [2][$];
  int   n_tests;
  int   n_fail;

  dlx_pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID_EN(1)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush_in(flush_in[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_ctrl(in_ctrl[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_ctrl(out_ctrl[0]),
    .out_data(out_data[0]), .occupancy(occ[0])
  );

  dlx_pipe_stage_reg #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .SKID_EN(0)) u_noskid (
    .clk(clk), .rst_n(rst_n), .flush_in(flush_in[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_ctrl(in_ctrl[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_ctrl(out_ctrl[1]),
    .out_data(out_data[1]), .occupancy(occ[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", nm, k, $time, act, exp);
    end
  endtask

  // Reference model: entries accepted at an edge join the queue; flush/reset empty it.
  task automatic model_loop();
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        if (!rst_n || flush_in[k]) sb[k].delete();
        else if (in_valid[k] && in_ready[k]) sb[k].push_back({in_ctrl[k], in_data[k]});
      end
    end
  endtask

  task automatic monitor_loop();
    int   sz;
    logic exp_rdy;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        for (int k = 0; k < 2; k++) begin
          sz      = sb[k].size();
          exp_rdy = (k == 0) ? (sz < 2) : (sz == 0 || out_ready[k]);
          chk("occupancy", k, 128'(occ[k]), 128'(sz));
          chk("in_ready", k, 128'(in_ready[k]), 128'(exp_rdy));
          chk("out_valid", k, 128'(out_valid[k]), 128'(sz != 0));
          if (!out_valid[k]) begin
            chk("bubble_ctrl", k, 128'(out_ctrl[k]), 128'(0));
          end else if (sz > 0) begin
            chk("head_entry", k, 128'({out_ctrl[k], out_data[k]}), 128'(sb[k][0]));
            if (out_ready[k]) void'(sb[k].pop_front());
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_all(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                           input logic ordy, input logic fl);
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = v;
      in_ctrl[k]   = c;
      in_data[k]   = d;
      out_ready[k] = ordy;
      flush_in[k]  = fl;
    end
  endtask

  initial begin
    logic [95:0] r96;
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive_all(1'b1, 8'hFF, 84'h123, 1'b1, 1'b0);
    fork
      model_loop();
      monitor_loop();
    join_none

    step();
    step();
    rst_n = 1'b1;
    drive_all(1'b0, '0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 128'(out_valid[k]), 128'(0));
      chk("rst_out_ctrl", k, 128'(out_ctrl[k]), 128'(0));
      chk("rst_out_data", k, 128'(out_data[k]), 128'(0));
      chk("rst_occupancy", k, 128'(occ[k]), 128'(0));
      chk("rst_in_ready", k, 128'(in_ready[k]), 128'(1));
    end

    // Streaming 1..16 with no stalls
    for (int i = 1; i <= 16; i++) begin
      drive_all(1'b1, 8'h05, DW'(i), 1'b1, 1'b0);
      step();
      if (i == 1) begin
        chk("stream_latency_valid", 0, 128'(out_valid[0]), 128'(1));
        chk("stream_latency_data", 0, 128'(out_data[0]), 128'(1));
      end
    end
    drive_all(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    step();

    // Skid fill and drain
    drive_all(1'b1, 8'h0A, 84'h11, 1'b0, 1'b0);
    step();
    drive_all(1'b1, 8'h0B, 84'h22, 1'b0, 1'b0);
    step();
    drive_all(1'b0, '0, '0, 1'b0, 1'b0);
    chk("skid_full_occ", 0, 128'(occ[0]), 128'(2));
    chk("skid_full_in_ready", 0, 128'(in_ready[0]), 128'(0));
    chk("skid_full_head", 0, 128'(out_data[0]), 128'(84'h11));
    step();
    chk("skid_stall_stable", 0, 128'(out_data[0]), 128'(84'h11));
    drive_all(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    chk("skid_drain_second", 0, 128'(out_data[0]), 128'(84'h22));
    chk("skid_drain_in_ready", 0, 128'(in_ready[0]), 128'(1));
    chk("skid_drain_occ", 0, 128'(occ[0]), 128'(1));
    step();
    chk("skid_empty_occ", 0, 128'(occ[0]), 128'(0));

    // Flush with two entries held and one offered
    drive_all(1'b1, 8'h0A, 84'h11, 1'b0, 1'b0);
    step();
    drive_all(1'b1, 8'h0B, 84'h22, 1'b0, 1'b0);
    step();
    drive_all(1'b1, 8'h0C, 84'h33, 1'b0, 1'b1);
    step();
    drive_all(1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      chk("flush_out_valid", k, 128'(out_valid[k]), 128'(0));
      chk("flush_out_ctrl", k, 128'(out_ctrl[k]), 128'(0));
      chk("flush_out_data", k, 128'(out_data[k]), 128'(0));
      chk("flush_occ", k, 128'(occ[k]), 128'(0));
      chk("flush_in_ready", k, 128'(in_ready[k]), 128'(1));
    end
    drive_all(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    step();

    // Combinational in_ready without skid
    drive_all(1'b1, 8'h0D, 84'h44, 1'b0, 1'b0);
    step();
    drive_all(1'b1, 8'h0E, 84'h55, 1'b0, 1'b0);
    #1;
    chk("noskid_stall_in_ready", 1, 128'(in_ready[1]), 128'(0));
    out_ready[0] = 1'b1;
    out_ready[1] = 1'b1;
    #1;
    chk("noskid_pass_in_ready", 1, 128'(in_ready[1]), 128'(1));
    step();
    drive_all(1'b0, '0, '0, 1'b1, 1'b0);
    chk("noskid_next_valid", 1, 128'(out_valid[1]), 128'(1));
    chk("noskid_next_data", 1, 128'(out_data[1]), 128'(84'h55));
    step();
    step();

    // Random stall/flush soak
    for (int c = 0; c < 10000; c++) begin
      for (int k = 0; k < 2; k++) begin
        r96          = {$urandom, $urandom, $urandom};
        in_valid[k]  = ($urandom_range(0, 99) < 70);
        in_ctrl[k]   = CW'($urandom);
        in_data[k]   = r96[DW-1:0];
        out_ready[k] = ($urandom_range(0, 99) >= 30);
        flush_in[k]  = ($urandom_range(0, 99) < 2);
      end
      step();
    end
    drive_all(1'b0, '0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step();
    for (int k = 0; k < 2; k++) begin
      chk("soak_all_drained", k, 128'(sb[k].size()), 128'(0));
      chk("soak_final_occ", k, 128'(occ[k]), 128'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
